retire_queue: RTL and testbench
===============================

// Module: retire_queue
// PURPOSE
//  In-order retire/write-back stage with a DEPTH-entry queue and non-blocking loads.
//  Sits after execute: accepts completed ALU results and issued loads, merges in-order
//  memory responses, aligns/extends load data, writes the register bank in program order.
//  Parametrised for RV32/RV64; a flush discards queued work and drops stale responses.
// PARAMETERS
//  XLEN   32  datapath width, 32 or 64
//  DEPTH  4   queue entries, power of 2, >=2
// PORTS
//  clk               in   1         clock, rising edge
//  reset_n           in   1         asynchronous active-low reset
//  flush_i           in   1         discard all queued entries
//  in_valid_i        in   1         instruction offered
//  in_ready_o        out  1         queue can accept (combinational)
//  in_is_load_i      in   1         entry is a load whose memory request is already issued
//  in_funct3_i       in   3         load type: 000 LB,001 LH,010 LW,011 LD,100 LBU,101 LHU,110 LWU
//  in_rd_i           in   5         destination register
//  in_result_i       in   XLEN      ALU result, or effective address for loads
//  mem_rvalid_i      in   1         load response valid, in issue order, max 1/cycle
//  mem_rdata_i       in   XLEN      naturally aligned memory word
//  regbank_we_o      out  1         write strobe (registered)
//  regbank_addr_o    out  5         write address (registered)
//  regbank_data_o    out  XLEN      write data (registered)
//  empty_o           out  1         queue empty
//  protocol_err_o    out  1         sticky: response with nothing outstanding
// BEHAVIOUR
//  Reset: queue empty, drop_cnt=0; regbank_we_o/addr/data=0, protocol_err_o=0, empty_o=1.
//  Enqueue on in_valid_i & in_ready_o. in_ready_o = !full & (drop_cnt + unfilled_loads < DEPTH).
//  Retire head at clock edge when head valid and (!is_load or data filled). Registered outputs:
//   accepted cycle T -> regbank_we_o in T+2 at earliest. Throughput 1 retire/cycle.
//  rd==0: entry retires, regbank_we_o stays 0.
//  Response: if drop_cnt>0 -> discarded, drop_cnt-1. Else fills oldest unfilled load
//   (fill pointer); fill may occur before entry reaches head. Else protocol_err_o<=1.
//  Response filling the head in cycle T retires at end of T+1 (data stored first).
//  Alignment: off = in_result_i[log2(XLEN/8)-1:0]; byte lane = off; half uses off with bit0
//   ignored; word uses off[2] (XLEN=64 only). Sign-extend LB/LH/LW, zero-extend LBU/LHU/LWU.
//  XLEN=32: LD decodes as LW, LWU as LW. Misalignment not checked (trapped upstream).
//  Flush (priority over enqueue and retire): all entries removed, no write next cycle,
//   in_valid_i ignored; drop_cnt <= drop_cnt + unfilled_loads - mem_rvalid_i.
//  Full: in_ready_o=0; simultaneous retire does not free a slot same cycle.
//  Reset mid-operation: all state cleared immediately (memory side reset together).
// TESTING
//  XLEN=32: ALU rd=5 res=0x1234 -> we=1 addr=5 data=0x1234 two cycles after accept.
//  LB addr ..03, rdata=0x80FF_0000 -> data=0xFFFF_FF80; LBU same -> 0x0000_0080.
//  Load rd=3 then ALU rd=4; response 3 cycles later -> rd=3 written before rd=4 (in order).
//  Queue 2 unfilled loads, flush, then 3 responses -> first 2 dropped, 3rd fills new load.
//  Fill DEPTH entries, no responses -> in_ready_o=0; one response -> head retires, ready=1.
//  XLEN=64 LWU addr ..04, rdata=0x8000_0001_xxxx_xxxx -> 0x0000_0000_8000_0001.

Source files
------------

// File: rtl/retire_queue.sv
// In-order retire/write-back stage: DEPTH-entry queue of ALU results and issued loads,
// in-order fill from memory responses, load alignment/extension, registered register-bank write.
module retire_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            in_is_load_i,
  input  logic [2:0]      in_funct3_i,
  input  logic [4:0]      in_rd_i,
  input  logic [XLEN-1:0] in_result_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            regbank_we_o,
  output logic [4:0]      regbank_addr_o,
  output logic [XLEN-1:0] regbank_data_o,
  output logic            empty_o,
  output logic            protocol_err_o
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int OFFW = $clog2(XLEN / 8);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] r_is_load;
  logic [DEPTH-1:0] r_filled;
  logic [2:0]       r_funct3 [DEPTH];
  logic [4:0]       r_rd     [DEPTH];
  logic [OFFW-1:0]  r_off    [DEPTH];
  logic [XLEN-1:0]  r_data   [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_drop;
  logic             r_we;
  logic [4:0]       r_addr;
  logic [XLEN-1:0]  r_wdata;
  logic             r_perr;

  logic [CW-1:0]    w_unfilled;
  logic             w_fill_hit;
  logic [PW-1:0]    w_fill_idx;
  logic [PW-1:0]    w_k;
  logic             w_cand;
  logic [CW-1:0]    w_sum;
  logic             w_full;
  logic             w_enq;
  logic             w_ret;
  logic             w_drop_nz;
  logic             w_fill;
  logic             w_perr;
  logic [XLEN-1:0]  w_load_data;

  // Select the addressed byte/half/word of a naturally aligned memory word and extend it.
  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] rdata,
                                                 input logic [OFFW-1:0] off,
                                                 input logic [2:0]      funct3);
    logic [XLEN-1:0] b_sh;
    logic [XLEN-1:0] h_sh;
    logic [XLEN-1:0] wd_sh;
    logic [XLEN-1:0] res;
    b_sh  = rdata >> {off, 3'b000};
    h_sh  = rdata >> {off[OFFW-1:1], 4'b0000};
    wd_sh = (XLEN == 64) ? (rdata >> {off[OFFW-1], 5'b00000}) : rdata;
    case (funct3)
      3'b000: begin res = {XLEN{b_sh[7]}};   res[7:0]  = b_sh[7:0];   end
      3'b001: begin res = {XLEN{h_sh[15]}};  res[15:0] = h_sh[15:0];  end
      3'b010: begin res = {XLEN{wd_sh[31]}}; res[31:0] = wd_sh[31:0]; end
      3'b011: begin
        if (XLEN == 64) begin
          res = rdata;
        end else begin
          res = {XLEN{wd_sh[31]}}; res[31:0] = wd_sh[31:0];
        end
      end
      3'b100: begin res = '0; res[7:0]  = b_sh[7:0];  end
      3'b101: begin res = '0; res[15:0] = h_sh[15:0]; end
      3'b110: begin
        if (XLEN == 64) begin
          res = '0; res[31:0] = wd_sh[31:0];
        end else begin
          res = {XLEN{wd_sh[31]}}; res[31:0] = wd_sh[31:0];
        end
      end
      default: res = rdata;
    endcase
    return res;
  endfunction

  // Walk the queue from the head: count unfilled loads and find the oldest one.
  always_comb begin
    w_unfilled = '0;
    w_fill_hit = 1'b0;
    w_fill_idx = r_head;
    w_k        = r_head;
    w_cand     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_k        = r_head + PW'(i);
      w_cand     = r_vld[w_k] & r_is_load[w_k] & ~r_filled[w_k];
      w_unfilled = w_unfilled + CW'(w_cand);
      w_fill_idx = (w_cand && !w_fill_hit) ? w_k : w_fill_idx;
      w_fill_hit = w_fill_hit | w_cand;
    end
  end

  // drop_cnt + unfilled never exceeds DEPTH, so CW bits hold the sum.
  assign w_sum       = r_drop + w_unfilled;
  assign w_full      = (r_count == CNT_DEPTH);
  assign in_ready_o  = !w_full && (w_sum < CNT_DEPTH);
  assign w_enq       = in_valid_i & in_ready_o & ~flush_i;
  assign w_ret       = ~flush_i & r_vld[r_head] & (~r_is_load[r_head] | r_filled[r_head]);
  assign w_drop_nz   = (r_drop != '0);
  assign w_fill      = mem_rvalid_i & ~w_drop_nz & w_fill_hit;
  assign w_perr      = mem_rvalid_i & ~w_drop_nz & ~w_fill_hit;
  assign w_load_data = align_load(mem_rdata_i, r_off[w_fill_idx], r_funct3[w_fill_idx]);

  // Queue state, response bookkeeping and the registered write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld     <= '0;
      r_is_load <= '0;
      r_filled  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_funct3[i] <= 3'b000;
        r_rd[i]     <= 5'd0;
        r_off[i]    <= '0;
        r_data[i]   <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_we    <= 1'b0;
      r_addr  <= 5'd0;
      r_wdata <= '0;
      r_perr  <= 1'b0;
    end else if (flush_i) begin
      // Every load still unfilled now has a response in flight that must be discarded.
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= w_sum - CW'(mem_rvalid_i & ~w_perr);
      r_we    <= 1'b0;
      if (w_perr) begin
        r_perr <= 1'b1;
      end
    end else begin
      if (w_ret) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_ONE;
        r_we          <= (r_rd[r_head] != 5'd0);
        r_addr        <= r_rd[r_head];
        r_wdata       <= r_data[r_head];
      end else begin
        r_we <= 1'b0;
      end
      if (w_enq) begin
        r_vld[r_tail]     <= 1'b1;
        r_is_load[r_tail] <= in_is_load_i;
        r_filled[r_tail]  <= 1'b0;
        r_funct3[r_tail]  <= in_funct3_i;
        r_rd[r_tail]      <= in_rd_i;
        r_off[r_tail]     <= in_result_i[OFFW-1:0];
        r_data[r_tail]    <= in_result_i;
        r_tail            <= r_tail + PTR_ONE;
      end
      if (w_fill) begin
        r_filled[w_fill_idx] <= 1'b1;
        r_data[w_fill_idx]   <= w_load_data;
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_ret);
      if (mem_rvalid_i && w_drop_nz) begin
        r_drop <= r_drop - CNT_ONE;
      end
      if (w_perr) begin
        r_perr <= 1'b1;
      end
    end
  end

  assign regbank_we_o   = r_we;
  assign regbank_addr_o = r_addr;
  assign regbank_data_o = r_wdata;
  assign empty_o        = (r_count == '0);
  assign protocol_err_o = r_perr;

endmodule

// File: tb/tb_retire_queue.sv
// Self-checking bench for retire_queue: directed cases plus randomized traffic against a
// queue-based reference model (XLEN=32), and a small XLEN=64 load-alignment instance.
module tb_retire_queue;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        flush, in_valid, in_ready, in_is_load, mem_rvalid;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, addr;
  logic [31:0] in_result, mem_rdata, data;
  logic        we, empty, perr;

  logic        d_flush, d_valid, d_ready, d_is_load, d_rvalid, d_we, d_empty, d_perr;
  logic [2:0]  d_funct3;
  logic [4:0]  d_rd, d_addr;
  logic [63:0] d_result, d_rdata, d_data;

  retire_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_is_load_i(in_is_load), .in_funct3_i(in_funct3),
    .in_rd_i(in_rd), .in_result_i(in_result), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .regbank_we_o(we), .regbank_addr_o(addr),
    .regbank_data_o(data), .empty_o(empty), .protocol_err_o(perr));

  retire_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush_i(d_flush), .in_valid_i(d_valid),
    .in_ready_o(d_ready), .in_is_load_i(d_is_load), .in_funct3_i(d_funct3),
    .in_rd_i(d_rd), .in_result_i(d_result), .mem_rvalid_i(d_rvalid),
    .mem_rdata_i(d_rdata), .regbank_we_o(d_we), .regbank_addr_o(d_addr),
    .regbank_data_o(d_data), .empty_o(d_empty), .protocol_err_o(d_perr));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference load extraction written as plain byte arithmetic.
  function automatic logic [63:0] ref_load(input int xlen, input logic [2:0] f3,
                                           input logic [63:0] a, input logic [63:0] rdata);
    int off;
    longint unsigned w, b, h, wd, mask;
    longint r;
    off  = int'(a[2:0]) % (xlen / 8);
    w    = rdata;
    b    = (w >> (8 * off)) & 64'hFF;
    h    = (w >> (8 * ((off / 2) * 2))) & 64'hFFFF;
    wd   = (xlen == 64) ? ((w >> (8 * ((off / 4) * 4))) & 64'hFFFF_FFFF) : (w & 64'hFFFF_FFFF);
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    case (f3)
      3'd0: r = (b >= 64'd128) ? longint'(b) - 64'sd256 : longint'(b);
      3'd1: r = (h >= 64'd32768) ? longint'(h) - 64'sd65536 : longint'(h);
      3'd2: r = (wd >= 64'h8000_0000) ? longint'(wd) - 64'sh1_0000_0000 : longint'(wd);
      3'd3: r = (xlen == 64) ? longint'(w) :
                ((wd >= 64'h8000_0000) ? longint'(wd) - 64'sh1_0000_0000 : longint'(wd));
      3'd4: r = longint'(b);
      3'd5: r = longint'(h);
      3'd6: r = (xlen == 64) ? longint'(wd) :
                ((wd >= 64'h8000_0000) ? longint'(wd) - 64'sh1_0000_0000 : longint'(wd));
      default: r = longint'(w);
    endcase
    return 64'(r) & mask;
  endfunction

  typedef struct {
    logic        is_load;
    logic        filled;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] val;
  } ent_t;

  ent_t        mq[$];
  int          m_drop;
  logic        m_we, m_err;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic int m_unfilled();
    int n = 0;
    foreach (mq[i]) if (mq[i].is_load && !mq[i].filled) n++;
    return n;
  endfunction

  function automatic bit m_ready();
    return (mq.size() < DEPTH) && ((m_drop + m_unfilled()) < DEPTH);
  endfunction

  task automatic m_reset();
    mq.delete();
    m_drop = 0; m_we = 1'b0; m_err = 1'b0; m_addr = 5'd0; m_data = 32'd0;
  endtask

  // One clock cycle: compare outputs with the model, drive inputs, advance the model.
  task automatic step(input logic fl, input logic v, input logic ld, input logic [2:0] f3,
                      input logic [4:0] rd, input logic [31:0] res,
                      input logic rv, input logic [31:0] rdata);
    bit   rdy, done;
    int   u;
    ent_t e;
    logic [63:0] ld_val;
    check("we", {63'd0, we}, {63'd0, m_we});
    check("addr", {59'd0, addr}, {59'd0, m_addr});
    check("data", {32'd0, data}, {32'd0, m_data});
    check("ready", {63'd0, in_ready}, {63'd0, m_ready()});
    check("empty", {63'd0, empty}, {63'd0, mq.size() == 0});
    check("perr", {63'd0, perr}, {63'd0, m_err});
    flush = fl; in_valid = v; in_is_load = ld; in_funct3 = f3; in_rd = rd;
    in_result = res; mem_rvalid = rv; mem_rdata = rdata;
    rdy = m_ready();
    if (fl) begin
      u = m_unfilled();
      if (rv) begin
        if (m_drop > 0) m_drop--;
        else if (u > 0) u--;
        else m_err = 1'b1;
      end
      m_drop += u;
      mq.delete();
      m_we = 1'b0;
    end else begin
      m_we = 1'b0;
      if (mq.size() > 0 && (!mq[0].is_load || mq[0].filled)) begin
        m_we   = (mq[0].rd != 5'd0);
        m_addr = mq[0].rd;
        m_data = mq[0].is_load ? mq[0].val : mq[0].res;
        void'(mq.pop_front());
      end
      if (rv) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          done = 1'b0;
          foreach (mq[i]) begin
            if (!done && mq[i].is_load && !mq[i].filled) begin
              ld_val       = ref_load(32, mq[i].f3, {32'd0, mq[i].res}, {32'd0, rdata});
              mq[i].val    = ld_val[31:0];
              mq[i].filled = 1'b1;
              done         = 1'b1;
            end
          end
          if (!done) m_err = 1'b1;
        end
      end
      if (v && rdy) begin
        e.is_load = ld; e.filled = 1'b0; e.f3 = f3; e.rd = rd; e.res = res; e.val = 32'd0;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b0, 32'd0);
  endtask

  int          rv_pct;
  logic [63:0] r64;

  initial begin
    reset_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_is_load = 1'b0; in_funct3 = 3'd0; in_rd = 5'd0;
    in_result = 32'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    d_flush = 1'b0; d_valid = 1'b0; d_is_load = 1'b0; d_funct3 = 3'd0; d_rd = 5'd0;
    d_result = 64'd0; d_rvalid = 1'b0; d_rdata = 64'd0;
    m_reset();
    repeat (2) @(negedge clk);
    check("rst_we", {63'd0, we}, 64'd0);
    check("rst_addr", {59'd0, addr}, 64'd0);
    check("rst_data", {32'd0, data}, 64'd0);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_perr", {63'd0, perr}, 64'd0);
    check("rst_empty64", {63'd0, d_empty}, 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // XLEN=64: LWU, LW and LD from the same memory word.
    r64 = 64'h8000_0001_1234_5678;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) begin
        check("lwu64_we", {63'd0, d_we}, 64'd1);
        check("lwu64_data", d_data, 64'h0000_0000_8000_0001);
      end
      if (c == 6) check("lw64_data", d_data, 64'hFFFF_FFFF_8000_0001);
      if (c == 7) begin
        check("ld64_addr", {59'd0, d_addr}, 64'd8);
        check("ld64_data", d_data, r64);
      end
      d_valid  = (c < 3);
      d_is_load = 1'b1;
      d_funct3 = (c == 0) ? 3'b110 : ((c == 1) ? 3'b010 : 3'b011);
      d_rd     = 5'(6 + c);
      d_result = (c == 2) ? 64'h100 : 64'h104;
      d_rvalid = (c >= 3) && (c <= 5);
      d_rdata  = r64;
      @(negedge clk);
    end
    d_valid = 1'b0; d_rvalid = 1'b0;
    check("empty64_end", {63'd0, d_empty}, 64'd1);

    // ALU result written two cycles after acceptance.
    step(1'b0, 1'b1, 1'b0, 3'd0, 5'd5, 32'h1234, 1'b0, 32'd0);
    idle(1);
    check("alu_we", {63'd0, we}, 64'd1);
    check("alu_addr", {59'd0, addr}, 64'd5);
    check("alu_data", {32'd0, data}, 64'h1234);

    // LB / LBU at byte offset 3.
    step(1'b0, 1'b1, 1'b1, 3'b000, 5'd7, 32'h1003, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 32'h80FF_0000);
    idle(1);
    check("lb_data", {32'd0, data}, 64'hFFFF_FF80);
    step(1'b0, 1'b1, 1'b1, 3'b100, 5'd7, 32'h1003, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 32'h80FF_0000);
    idle(1);
    check("lbu_data", {32'd0, data}, 64'h0000_0080);

    // Load then ALU: writes stay in program order.
    step(1'b0, 1'b1, 1'b1, 3'b010, 5'd3, 32'h40, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 5'd4, 32'h44, 1'b0, 32'd0);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 32'h1111_2222);
    idle(1);
    check("order_first", {59'd0, addr}, 64'd3);
    check("order_first_data", {32'd0, data}, 64'h1111_2222);
    idle(1);
    check("order_second", {59'd0, addr}, 64'd4);

    // Flush with two loads outstanding: two responses dropped, the third fills.
    step(1'b0, 1'b1, 1'b1, 3'b010, 5'd1, 32'h10, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 3'b010, 5'd2, 32'h14, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'd0, 5'd30, 32'h99, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 3'b010, 5'd9, 32'h2000, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 32'hAAAA_AAAA);
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 32'hBBBB_BBBB);
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 32'hCAFE_BABE);
    idle(1);
    check("flush_fill_addr", {59'd0, addr}, 64'd9);
    check("flush_fill_data", {32'd0, data}, 64'hCAFE_BABE);

    // Full queue of unfilled loads; one response retires the head and frees a slot.
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, 1'b1, 3'b010, 5'(11 + i), 32'(16 * i), 1'b0, 32'd0);
    check("full_ready", {63'd0, in_ready}, 64'd0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 5'd20, 32'h55, 1'b1, 32'hA5A5_0001);
    check("full_ready_hold", {63'd0, in_ready}, 64'd0);
    idle(1);
    check("full_ready_free", {63'd0, in_ready}, 64'd1);
    check("full_retire_addr", {59'd0, addr}, 64'd11);
    for (int i = 0; i < DEPTH - 1; i++)
      step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 32'(32'h0F00_0000 + i));
    idle(3);

    // Response with nothing outstanding.
    step(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 1'b1, 32'h1);
    check("perr_set", {63'd0, perr}, 64'd1);
    idle(1);

    // Asynchronous reset in the middle of traffic.
    step(1'b0, 1'b1, 1'b1, 3'b001, 5'd12, 32'h22, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 3'd0, 5'd13, 32'h77, 1'b0, 32'd0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midrst_empty", {63'd0, empty}, 64'd1);
    check("midrst_we", {63'd0, we}, 64'd0);
    check("midrst_perr", {63'd0, perr}, 64'd0);
    check("midrst_ready", {63'd0, in_ready}, 64'd1);
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic with varying response pressure.
    rv_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      logic fl, v, ld, rv;
      if (n % 500 == 0) rv_pct = $urandom_range(10, 90);
      fl = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      ld = $urandom_range(0, 1);
      rv = ((m_drop + m_unfilled()) > 0) && ($urandom_range(0, 99) < rv_pct);
      step(fl, v, ld, 3'($urandom_range(0, 6)), 5'($urandom_range(0, 31)), $urandom,
           rv, $urandom);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
